// File: rtl/readout_packer_if.sv
// readout_packer_if: frame input, host pipe-out and status bundle for readout_packer
interface readout_packer_if #(parameter int DEPTH_LOG2 = 10);
    logic [39:0] frame_data;
    logic frame_valid, enable, pipe_rd, clr_flags;
    logic [31:0] pipe_data;
    logic block_ready, overflow, underflow;
    logic [DEPTH_LOG2:0] fifo_count;
    logic [15:0] drop_cnt;
    modport master (
        output frame_data, frame_valid, enable, pipe_rd, clr_flags,
        input pipe_data, block_ready, fifo_count, overflow, underflow, drop_cnt
    );
    modport slave (
        input frame_data, frame_valid, enable, pipe_rd, clr_flags,
        output pipe_data, block_ready, fifo_count, overflow, underflow, drop_cnt
    );
endinterface

// File: rtl/readout_packer.sv
// readout_packer: splits 40-bit ADC frames into tagged 32-bit channel words buffered in a FIFO for host pipe-out
module readout_packer #(
    parameter int DEPTH_LOG2 = 10,
    parameter int BLOCK_WORDS = 256,
    parameter logic [3:0] TAG_CH1 = 4'hA,
    parameter logic [3:0] TAG_CH2 = 4'hB
) (
    input logic SYS_CLK,
    input logic RST,
    readout_packer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;
    state_t state;
    logic [39:0] frame;
    logic [7:0] seq;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [31:0] mem [DEPTH];
    logic wr, rd, room, accept, drop;
    logic [DEPTH_LOG2:0] cnt_nx;
    logic [31:0] wr_word;
    // both words of a frame are reserved at acceptance, so WR1/WR2 never see a full FIFO
    assign wr = state != IDLE;
    assign rd = bus.pipe_rd && bus.fifo_count != '0;
    assign room = int'(bus.fifo_count) <= DEPTH - 2;
    assign accept = bus.frame_valid && bus.enable && !wr && room;
    assign drop = bus.frame_valid && bus.enable && !accept;
    assign cnt_nx = bus.fifo_count + (DEPTH_LOG2+1)'(wr) - (DEPTH_LOG2+1)'(rd);
    assign wr_word = state == WR1 ? {TAG_CH1, seq, frame[19:0]} : {TAG_CH2, seq, frame[39:20]};
    always_ff @(posedge SYS_CLK) if (wr) mem[wr_ptr] <= wr_word;
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            frame <= '0;
            seq <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            bus.pipe_data <= '0;
            bus.block_ready <= 1'b0;
            bus.fifo_count <= '0;
            bus.overflow <= 1'b0;
            bus.underflow <= 1'b0;
            bus.drop_cnt <= '0;
        end else begin
            state <= accept ? WR1 : state == WR1 ? WR2 : IDLE;
            if (accept) frame <= bus.frame_data;
            if (state == WR2) seq <= seq + 8'd1;
            wr_ptr <= wr_ptr + DEPTH_LOG2'(wr);
            rd_ptr <= rd_ptr + DEPTH_LOG2'(rd);
            if (rd) bus.pipe_data <= mem[rd_ptr];
            bus.fifo_count <= cnt_nx;
            bus.block_ready <= int'(cnt_nx) >= BLOCK_WORDS;
            bus.overflow <= drop || (bus.overflow && !bus.clr_flags);
            bus.underflow <= (bus.pipe_rd && !rd) || (bus.underflow && !bus.clr_flags);
            bus.drop_cnt <= drop ? (bus.clr_flags ? 16'd1 : &bus.drop_cnt ? bus.drop_cnt : bus.drop_cnt + 16'd1)
                                 : bus.clr_flags ? '0 : bus.drop_cnt;
        end
    end
endmodule
